// File: rtl/modn_counter_unit.sv
// modn_counter_unit
//   Modulo-N counter driven from the board clock through a tick-enable divider.
//   Button and switch inputs are synchronised; the button is also debounced.
//   A press, with enable set, steps the user operand `data`. On each tick the
//   synchronised opcode updates `result` using `data` as the operand.
//
// Ports
//   clk          board clock; the only clock domain
//   reset_async  asynchronous active-low reset
//   data_inc     raw push button, active-low; a press steps `data`
//   opcode[2:0]  raw switches that select the counter operation
//   enable       raw switch, active-high; gates data entry
//   data         user operand, 0..N-1
//   result       counter value, 0..N-1
//   y            XOR of all bits of `result`
//   tick         one-cycle strobe; `result` updates at the end of this cycle
//   wrap         one-cycle strobe that accompanies a `result` update which
//                crossed the modulus
module modn_counter_unit #(
    parameter int N        = 9,
    parameter int WIDTH    = 4,
    parameter int DIV      = 1000000,
    parameter int DEBOUNCE = 10000
) (
    input  logic             clk,
    input  logic             reset_async,
    input  logic             data_inc,
    input  logic [2:0]       opcode,
    input  logic             enable,
    output logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] result,
    output logic             y,
    output logic             tick,
    output logic             wrap
);

    localparam int CW = $clog2(DIV);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [WIDTH:0]   NX  = (WIDTH+1)'(N);
    localparam logic [WIDTH-1:0] NM1 = WIDTH'(N - 1);

    typedef enum logic [2:0] {
        OP_HOLD  = 3'b000,
        OP_UP    = 3'b001,
        OP_DOWN  = 3'b010,
        OP_LOAD  = 3'b011,
        OP_ADD   = 3'b100,
        OP_SUB   = 3'b101,
        OP_CLEAR = 3'b110,
        OP_NEG   = 3'b111
    } op_e;

    // ------------------------------------------------------------------
    // Input synchronisers. Index 0 samples the pin; index 1 is the output.
    // ------------------------------------------------------------------
    logic [1:0]      btn_sync;
    logic [1:0]      en_sync;
    logic [1:0][2:0] op_sync;

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            btn_sync <= '1;   // released
            en_sync  <= '0;
            op_sync  <= '0;
        end else begin
            btn_sync <= {btn_sync[0], data_inc};
            en_sync  <= {en_sync[0], enable};
            op_sync  <= {op_sync[0], opcode};
        end
    end

    logic btn_s, en_s;
    op_e  op_s;
    assign btn_s = btn_sync[1];
    assign en_s  = en_sync[1];
    assign op_s  = op_e'(op_sync[1]);

    // ------------------------------------------------------------------
    // Debouncer: the filtered level follows the button only after DEBOUNCE
    // consecutive samples that disagree with it. filt_d delays the level by
    // one cycle so that the press (1->0) edge becomes a registered step.
    // ------------------------------------------------------------------
    logic [DW-1:0] db_cnt;
    logic          filt, filt_d;

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            db_cnt <= '0;
            filt   <= 1'b1;
            filt_d <= 1'b1;
        end else begin
            filt_d <= filt;
            if (btn_s == filt) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE - 1)) begin
                filt   <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    logic step;
    assign step = filt_d & ~filt & en_s;

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async)
            data <= '0;
        else if (step)
            data <= (data == NM1) ? '0 : data + WIDTH'(1);
    end

    // ------------------------------------------------------------------
    // Tick divider. tick is registered from the next count, which makes it
    // high during exactly the cycle in which the count equals DIV-1.
    // ------------------------------------------------------------------
    logic [CW-1:0] div_cnt, div_nxt;

    assign div_nxt = (div_cnt == CW'(DIV - 1)) ? '0 : div_cnt + CW'(1);

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            tick    <= (div_nxt == CW'(DIV - 1));
        end
    end

    // ------------------------------------------------------------------
    // Counter operation. The arithmetic is WIDTH+1 bits wide, so the sum
    // (or result+N on a borrow) cannot overflow before the single correction.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   sum, sub_wrap;
    logic [WIDTH-1:0] res_nxt;
    logic             wrap_nxt;

    assign sum      = {1'b0, result} + {1'b0, data};
    assign sub_wrap = {1'b0, result} + NX - {1'b0, data};

    always_comb begin
        res_nxt  = result;
        wrap_nxt = 1'b0;
        case (op_s)
            OP_HOLD: res_nxt = result;
            OP_UP: begin
                if (result == NM1) begin
                    res_nxt  = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    res_nxt = result + WIDTH'(1);
                end
            end
            OP_DOWN: begin
                if (result == '0) begin
                    res_nxt  = NM1;
                    wrap_nxt = 1'b1;
                end else begin
                    res_nxt = result - WIDTH'(1);
                end
            end
            OP_LOAD: res_nxt = data;
            OP_ADD: begin
                if (sum >= NX) begin
                    res_nxt  = WIDTH'(sum - NX);
                    wrap_nxt = 1'b1;
                end else begin
                    res_nxt = WIDTH'(sum);
                end
            end
            OP_SUB: begin
                if (data > result) begin
                    res_nxt  = WIDTH'(sub_wrap);
                    wrap_nxt = 1'b1;
                end else begin
                    res_nxt = result - data;
                end
            end
            OP_CLEAR: res_nxt = '0;
            OP_NEG:   res_nxt = (result == '0) ? '0 : WIDTH'(NX - {1'b0, result});
            default:  res_nxt = result;
        endcase
    end

    // y is computed from the same next value, so it never lags result.
    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            result <= '0;
            y      <= 1'b0;
            wrap   <= 1'b0;
        end else if (tick) begin
            result <= res_nxt;
            y      <= ^res_nxt;
            wrap   <= wrap_nxt;
        end else begin
            wrap   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_modn_counter_unit.sv
// Testbench for modn_counter_unit (N=9, WIDTH=4, DIV=4, DEBOUNCE=3).
// A behavioural model is built from a history of input samples indexed by
// edge number since reset release. It is checked against the DUT at every
// falling edge. The directed scenarios also pin hand-computed values.
module tb_modn_counter_unit;

    localparam int N = 9, WIDTH = 4, DIV = 4, DEB = 3;

    logic             clk = 1'b0;
    logic             reset_async, data_inc, enable;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] data, result;
    logic             y, tick, wrap;

    int n_chk  = 0;
    int n_fail = 0;

    modn_counter_unit #(.N(N), .WIDTH(WIDTH), .DIV(DIV), .DEBOUNCE(DEB)) dut (
        .clk(clk), .reset_async(reset_async), .data_inc(data_inc),
        .opcode(opcode), .enable(enable), .data(data), .result(result),
        .y(y), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   k      = 0;      // edges since reset release
    int   m_res  = 0;
    int   m_data = 0;
    int   m_wrap = 0;
    logic m_filt = 1'b1;
    bit   pend   = 1'b0;
    logic       btn_h [0:8191];
    logic [2:0] op_h  [0:8191];
    logic       en_h  [0:8191];

    always @(posedge clk or negedge reset_async) begin : model
        int b, o, e, r, d, idx, s;
        bit all_diff;
        if (!reset_async) begin
            k = 0; m_res = 0; m_data = 0; m_wrap = 0; m_filt = 1'b1; pend = 1'b0;
        end else begin
            k++;
            btn_h[k] = data_inc;
            op_h[k]  = opcode;
            en_h[k]  = enable;
            // the logic sees the pin values from two edges earlier
            b = (k > 2) ? int'(btn_h[k-2]) : 1;
            o = (k > 2) ? int'(op_h[k-2])  : 0;
            e = (k > 2) ? int'(en_h[k-2])  : 0;
            m_wrap = 0;
            if ((k - 1) % DIV == DIV - 1) begin
                r = m_res; d = m_data;
                case (o)
                    1: begin m_res = (r + 1) % N;     m_wrap = int'(r == N - 1); end
                    2: begin m_res = (r + N - 1) % N; m_wrap = int'(r == 0);     end
                    3: m_res = d;
                    4: begin m_res = (r + d) % N;     m_wrap = int'(r + d >= N); end
                    5: begin m_res = (r - d + N) % N; m_wrap = int'(d > r);      end
                    6: m_res = 0;
                    7: m_res = (N - r) % N;
                    default: ;
                endcase
            end
            if (pend && e == 1) m_data = (m_data + 1) % N;
            pend = 1'b0;
            // level accepted once the last DEB samples all disagree with it
            all_diff = 1'b1;
            for (int i = 0; i < DEB; i++) begin
                idx = k - 2 - i;
                s = (idx >= 1) ? int'(btn_h[idx]) : 1;
                if (s == int'(m_filt)) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_filt = ~m_filt;
                pend = (m_filt == 1'b0);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("tick",   int'(tick),   int'(k > 0 && k % DIV == DIV - 1));
        chk("result", int'(result), m_res);
        chk("data",   int'(data),   m_data);
        chk("y",      int'(y),      $countones(m_res) % 2);
        chk("wrap",   int'(wrap),   m_wrap);
    end

    // ---------------- stimulus ----------------
    task automatic press(input int lo, input int hi);
        data_inc = 1'b0;
        repeat (lo) @(negedge clk);
        data_inc = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    task automatic align(input int p);
        for (int i = 0; i < DIV && (k % DIV) != p; i++) @(negedge clk);
    endtask

    // One tick with opcode op, then back to HOLD; returns just after the update.
    task automatic apply_op(input logic [2:0] op);
        align(0);
        opcode = op;
        repeat (4) @(negedge clk);
        opcode = 3'b000;
    endtask

    initial begin
        reset_async = 1'b1; data_inc = 1'b1; opcode = 3'b000; enable = 1'b0;
        #1 reset_async = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_result", int'(result), 0);
        chk("rst_data", int'(data), 0);
        opcode = 3'b001; enable = 1'b1;
        @(negedge clk) reset_async = 1'b1;

        // UP count
        repeat (2) @(negedge clk);
        chk("tick_c3", int'(tick), 0);
        @(negedge clk);
        chk("tick_c4", int'(tick), 1);
        repeat (25) @(negedge clk);
        chk("up7", int'(result), 7);
        chk("up7_y", int'(y), 1);
        repeat (4) @(negedge clk);
        chk("up8", int'(result), 8);
        chk("up8_wrap", int'(wrap), 0);
        repeat (4) @(negedge clk);
        chk("up_wrap0", int'(result), 0);
        chk("up_wrap", int'(wrap), 1);
        opcode = 3'b000;

        // data entry
        repeat (10) press(10, 10);
        chk("press10", int'(data), 1);
        press(2, 10);
        chk("glitch", int'(data), 1);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        repeat (3) press(10, 10);
        chk("en_off", int'(data), 1);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        repeat (4) press(10, 10);
        chk("data5", int'(data), 5);

        // opcode set
        apply_op(3'b011); chk("load", int'(result), 5);
        apply_op(3'b100); chk("add", int'(result), 1); chk("add_wrap", int'(wrap), 1);
        apply_op(3'b001);
        apply_op(3'b001); chk("up3", int'(result), 3);
        apply_op(3'b101); chk("sub", int'(result), 7); chk("sub_wrap", int'(wrap), 1);
        apply_op(3'b111); chk("neg7", int'(result), 2); chk("neg_wrap", int'(wrap), 0);
        apply_op(3'b110); chk("clr", int'(result), 0);
        apply_op(3'b111); chk("neg0", int'(result), 0);
        apply_op(3'b010); chk("down0", int'(result), 8); chk("down_wrap", int'(wrap), 1);
        apply_op(3'b110); chk("clr2", int'(result), 0); chk("clr_wrap", int'(wrap), 0);

        // press that completes on the LOAD update edge
        repeat (6) press(10, 10);
        chk("data2", int'(data), 2);
        align(2);
        data_inc = 1'b0;
        repeat (2) @(negedge clk);
        opcode = 3'b011;
        repeat (4) @(negedge clk);
        opcode = 3'b000;
        chk("same_res", int'(result), 2);
        chk("same_data", int'(data), 3);
        repeat (4) @(negedge clk);
        data_inc = 1'b1;
        repeat (10) @(negedge clk);

        // asynchronous reset mid-debounce and mid-divide
        data_inc = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_async = 1'b0;
        #1;
        chk("arst_result", int'(result), 0);
        chk("arst_data", int'(data), 0);
        chk("arst_y", int'(y), 0);
        chk("arst_tick", int'(tick), 0);
        chk("arst_wrap", int'(wrap), 0);
        @(negedge clk) reset_async = 1'b1;
        repeat (2) @(negedge clk);
        chk("rtick_c3", int'(tick), 0);
        data_inc = 1'b1;
        @(negedge clk);
        chk("rtick_c4", int'(tick), 1);
        repeat (10) @(negedge clk);
        chk("no_partial", int'(data), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
